stage_ex_mdu: RTL and testbench
===============================

STAGE_EX_MDU -- requirements
Module: stage_ex_mdu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter MUL_LAT, default 2, legal 1..4: multiply latency in cycles.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 squash_i  in  1  hazard-unit kill of the in-flight op.
REQ-007 stall_i  in  1  downstream stall; output register holds.
REQ-008 valid_i  in  1  ID/EX instruction valid.
REQ-009 md_en_i  in  1  instruction is RV32M/RV64M multiply or divide.
REQ-010 md_op_i  in  md_op_t  M-extension func3.
REQ-011 op1_i, op2_i  in  XLEN  rs1 and rs2 operands.
REQ-012 rd_addr_i  in  5  destination register.
REQ-013 busy_o  out  1  stall request to the hazard unit.
REQ-014 out_valid_o  out  1  registered result valid.
REQ-015 result_o  out  XLEN  registered result.
REQ-016 rd_addr_o  out  5  registered destination.
REQ-017 illegal_o  out  1  registered flag for an unsupported op.

Function
REQ-018 The block accepts an op in IDLE when valid_i && md_en_i && !squash_i; it latches operands, op and rd at that edge. Cycle N is the accept cycle.
REQ-019 FSM states SHALL be IDLE, MUL, DIV and DONE.
- IDLE->MUL on a multiply.
- IDLE->DIV on a divide.
- MUL/DIV->DONE on completion while stall_i is high.
- DONE->IDLE when !stall_i.
- Any state->IDLE on squash_i.
REQ-020 Completion latency L SHALL be MUL_LAT for MUL/MULH/MULHSU/MULHU, XLEN+1 for DIV/DIVU/REM/REMU (XLEN restoring iterations plus one sign-fix), and 1 for divide special cases.
REQ-021 The result SHALL be registered at the end of cycle N+L-1, so out_valid_o is high for exactly one unstalled cycle, at N+L.
REQ-022 busy_o SHALL be high from cycle N through N+L-2, and in DONE. It is low in the completion cycle so upstream advances together with the result.
REQ-023 MULH/MULHSU/MULHU SHALL return bits [2*XLEN-1:XLEN] of the signed×signed, signed×unsigned and unsigned×unsigned products; MUL returns bits [XLEN-1:0].
REQ-024 Divide by zero: quotient all-ones, remainder = dividend, L=1.
REQ-025 Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0, L=1.
REQ-026 Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-027 squash_i in any cycle SHALL abort the op; out_valid_o is 0 at the next edge and nothing is registered.
REQ-028 While stall_i is high, the output register and out_valid_o SHALL hold.
REQ-029 An op presented while the FSM is not IDLE is ignored.

Reset
REQ-030 On rst_ni low the FSM SHALL go to IDLE immediately, including mid-operation.
REQ-031 On rst_ni low these outputs SHALL be 0: out_valid_o, result_o, rd_addr_o, illegal_o and busy_o.
REQ-032 The iteration counter and partial remainder SHALL clear on reset; the first op after release behaves normally.

Configuration
REQ-033 Macro MDU_DIV_EN defined: divide ops behave as above.
REQ-034 Macro MDU_DIV_EN undefined: the divider is not instantiated. Divide ops complete with L=1, result_o=0 and illegal_o=1 with out_valid_o; multiply behaviour is unchanged.

Structure
REQ-035 md_op_t (func3 enum) and the MDU FSM state typedef SHALL live in the shared util package.
REQ-036 The iterative divider SHALL be the sub-module md_divider (start/done handshake, XLEN parameter). The multiplier SHALL be an inline MUL_LAT-deep register delay.

Verification (XLEN=32, MUL_LAT=2)
REQ-037 MUL 7×0xFFFFFFFD -> result_o 0xFFFFFFEB with out_valid_o at N+2.
REQ-038 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 MULH 0x80000000×0x80000000 -> 0x40000000.
REQ-040 DIV 100/7 -> 14 at N+33.
REQ-041 REM 100/7 -> 2.
REQ-042 DIV -7/2 -> 0xFFFFFFFD.
REQ-043 REM -7/2 -> 0xFFFFFFFF.
REQ-044 DIVU 5/0 -> 0xFFFFFFFF at N+1.
REQ-045 REMU 5/0 -> 5.
REQ-046 DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-047 REM 0x80000000/0xFFFFFFFF -> 0.
REQ-048 squash_i at N+10 of a divide -> busy_o 0 at N+11, no out_valid_o.
REQ-049 The next op after a squash completes correctly.
REQ-050 stall_i held 3 cycles at completion -> result and out_valid_o held, busy_o high, then IDLE.
REQ-051 rst_ni low mid-divide -> all outputs 0 asynchronously.
REQ-052 Build without MDU_DIV_EN -> DIV gives illegal_o=1 and result_o=0.

Source files
------------

// File: rtl/stage_ex_mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Holds the M-extension func3 encoding, the MDU FSM state type and
// small op-decode helpers used by the top and the divider.
package stage_ex_mdu_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

  // func3[2] separates divide/remainder from multiply
  function automatic logic op_is_div(input md_op_t op);
    return op[2];
  endfunction

  // DIV and REM are the signed divide flavours (func3[0] clear)
  function automatic logic op_is_signed_div(input md_op_t op);
    return op[2] & ~op[0];
  endfunction

  function automatic logic op_is_rem(input md_op_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/stage_ex_mdu_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Latency: XLEN iterations (first on the start edge) then done_o with sign-fixed result.
// Backpressure: none; result_o is valid only while done_o is high, abort_i drops the op.
// Ports: start_i/abort_i control, signed_i/rem_i select flavour, done_o/result_o out.
module md_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  logic            run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, rsel_q, rsel_d;

  logic [XLEN-1:0] r_in, q_in, d_in, r_nx, q_nx;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    rsel_d = rsel_q;

    // The start edge already performs the first iteration on the magnitudes,
    // which is what lets the whole op fit in XLEN+1 cycles.
    if (start_i) begin
      r_in = '0;
      q_in = (signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
      d_in = (signed_i && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
    end else begin
      r_in = rem_q;
      q_in = quo_q;
      d_in = dvs_q;
    end

    shifted = {r_in, q_in[XLEN-1]};
    diff    = shifted - {1'b0, d_in};
    r_nx    = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    q_nx    = {q_in[XLEN-2:0], ~diff[XLEN]};

    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d  = 1'b1;
      cnt_d  = CW'(XLEN - 1);
      rem_d  = r_nx;
      quo_d  = q_nx;
      dvs_d  = d_in;
      qneg_d = signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      rneg_d = signed_i & dividend_i[XLEN-1];
      rsel_d = rem_i;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        rem_d = r_nx;
        quo_d = q_nx;
        cnt_d = cnt_q - 1'b1;
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      rsel_q <= rsel_d;
    end
  end

  // Sign fix: quotient negative when operand signs differ, remainder follows dividend.
  assign done_o   = run_q && (cnt_q == '0);
  assign result_o = rsel_q ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);

endmodule

// File: rtl/stage_ex_mdu.sv
// EX-stage RV M-extension unit: pipelined multiply, iterative divide (build macro MDU_DIV_EN).
// Latency: MUL_LAT for multiplies, XLEN+1 for divides, 1 for divide special cases / disabled divider.
// Backpressure: busy_o stalls upstream while in flight; stall_i freezes a presented result (DONE).
// Ports: squash_i/stall_i from hazard unit, valid_i/md_en_i/md_op_i/op1_i/op2_i/rd_addr_i in,
//        busy_o to hazard unit, registered out_valid_o/result_o/rd_addr_o/illegal_o out.
module stage_ex_mdu
  import stage_ex_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            squash_i,
  input  logic            stall_i,
  input  logic            valid_i,
  input  logic            md_en_i,
  input  md_op_t          md_op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            illegal_o
);

  // Product delay line depth; the output register supplies the last stage.
  localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  mdu_state_t      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] mul_pipe_q [PD];
  logic [XLEN-1:0] mul_pipe_d [PD];
  logic            out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic                   is_div_op, accept, quick, complete, busy;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0]        mul_res, spec_res, quick_res, cmp_res, div_res;
  logic                   spec_ill, quick_ill, div_special, div_done, cmp_ill;
  logic [4:0]             cmp_rd;

  assign is_div_op = op_is_div(md_op_i);
  // A presented result frozen by stall_i still owns the output register.
  assign accept = (state_q == MDU_IDLE) && valid_i && md_en_i && !squash_i &&
                  !(out_valid_q && stall_i);

  // One (XLEN+1)-bit signed multiply covers all four flavours via operand extension.
  always_comb begin
    mul_a   = {(md_op_i == MD_MULH || md_op_i == MD_MULHSU) & op1_i[XLEN-1], op1_i};
    mul_b   = {(md_op_i == MD_MULH) & op2_i[XLEN-1], op2_i};
    prod    = mul_a * mul_b;
    mul_res = (md_op_i == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MDU_DIV_EN
  logic div_zero, div_ovf;

  always_comb begin
    div_zero    = (op2_i == '0);
    div_ovf     = op_is_signed_div(md_op_i) && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op2_i);
    div_special = div_zero || div_ovf;
    spec_ill    = 1'b0;
    if (div_zero) spec_res = op_is_rem(md_op_i) ? op1_i : '1;
    else          spec_res = op_is_rem(md_op_i) ? '0 : op1_i;
  end

  md_divider #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .start_i    (accept && is_div_op && !div_special),
    .abort_i    (squash_i),
    .signed_i   (op_is_signed_div(md_op_i)),
    .rem_i      (op_is_rem(md_op_i)),
    .dividend_i (op1_i),
    .divisor_i  (op2_i),
    .done_o     (div_done),
    .result_o   (div_res)
  );
`else
  // No divider: every divide finishes on the accept edge flagged illegal.
  assign div_special = 1'b1;
  assign spec_res    = '0;
  assign spec_ill    = 1'b1;
  assign div_done    = 1'b0;
  assign div_res     = '0;
`endif

  // Ops that complete on the accept edge itself (L=1).
  assign quick     = is_div_op ? div_special : (MUL_LAT == 1);
  assign quick_res = is_div_op ? spec_res : mul_res;
  assign quick_ill = is_div_op & spec_ill;

  always_comb begin
    mul_pipe_d[0] = mul_res;
    for (int i = 1; i < PD; i++) mul_pipe_d[i] = mul_pipe_q[i-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    complete = 1'b0;
    busy     = 1'b0;
    cmp_res  = quick_res;
    cmp_rd   = rd_q;
    cmp_ill  = 1'b0;

    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          rd_d = rd_addr_i;
          if (quick) begin
            complete = 1'b1;
            cmp_rd   = rd_addr_i;
            cmp_ill  = quick_ill;
            state_d  = stall_i ? MDU_DONE : MDU_IDLE;
          end else begin
            busy    = 1'b1;
            cnt_d   = (MUL_LAT >= 2) ? 3'(MUL_LAT - 2) : 3'd0;
            state_d = is_div_op ? MDU_DIV : MDU_MUL;
          end
        end
      end
      MDU_MUL: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          cmp_res  = mul_pipe_q[PD-1];
          state_d  = stall_i ? MDU_DONE : MDU_IDLE;
        end else begin
          busy  = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end
      end
      MDU_DIV: begin
        if (div_done) begin
          complete = 1'b1;
          cmp_res  = div_res;
          state_d  = stall_i ? MDU_DONE : MDU_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      MDU_DONE: begin
        busy = 1'b1;
        if (!stall_i) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase

    if (squash_i) state_d = MDU_IDLE;

    out_valid_d = 1'b0;
    result_d    = result_q;
    rd_out_d    = rd_out_q;
    illegal_d   = illegal_q;
    if (squash_i) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && stall_i) begin
      out_valid_d = 1'b1;
    end else if (complete) begin
      out_valid_d = 1'b1;
      result_d    = cmp_res;
      rd_out_d    = cmp_rd;
      illegal_d   = cmp_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= MDU_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_out_q    <= '0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < PD; i++) mul_pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd_out_q    <= rd_out_d;
      illegal_q   <= illegal_d;
      for (int i = 0; i < PD; i++) mul_pipe_q[i] <= mul_pipe_d[i];
    end
  end

  // busy is partly combinational from valid_i, so force it low during reset.
  assign busy_o      = rst_ni & busy;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign rd_addr_o   = rd_out_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_stage_ex_mdu.sv
module tb_stage_ex_mdu;
  import stage_ex_mdu_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic        clk, rst_ni, squash_i, stall_i, valid_i, md_en_i;
  md_op_t      md_op_i;
  logic [31:0] op1_i, op2_i, result_o;
  logic [4:0]  rd_addr_i, rd_addr_o;
  logic        busy_o, out_valid_o, illegal_o;

  stage_ex_mdu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_ni(rst_ni), .squash_i(squash_i), .stall_i(stall_i),
    .valid_i(valid_i), .md_en_i(md_en_i), .md_op_i(md_op_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i),
    .busy_o(busy_o), .out_valid_o(out_valid_o), .result_o(result_o),
    .rd_addr_o(rd_addr_o), .illegal_o(illegal_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  int tests = 0, fails = 0, cyc = 0, nissued = 0, nout = 0;
  logic prev_valid = 1'b0, prev_stall = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: results straight from the M-extension arithmetic rules.
  function automatic void ref_model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill, output int lat);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    ia = $signed(a); ib = $signed(b);
    ill = 1'b0; lat = MUL_LAT; r = '0;
    case (op)
      MD_MUL:    begin up = ua * ub; r = up[31:0]; end
      MD_MULH:   begin p = sa * sb; r = p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      MD_MULHU:  begin up = ua * ub; r = up[63:32]; end
      default: begin
`ifdef MDU_DIV_EN
        lat = XLEN + 1;
        if (b == 32'd0) begin
          lat = 1;
          r = (op == MD_DIV || op == MD_DIVU) ? 32'hFFFF_FFFF : a;
        end else if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 1;
          r = (op == MD_DIV) ? a : 32'd0;
        end else begin
          case (op)
            MD_DIV:  r = 32'(ia / ib);
            MD_REM:  r = 32'(ia % ib);
            MD_DIVU: r = a / b;
            default: r = a % b;
          endcase
        end
`else
        lat = 1; r = '0; ill = 1'b1;
`endif
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops an expectation on each newly presented result, checks holds while stalled.
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (out_valid_o) begin
        if (!(prev_valid && prev_stall)) begin
          nout++;
          if (expq.size() == 0) begin
            chk("unexpected_output", 32'(out_valid_o), 32'd0);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("result", result_o, e.res);
            chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
            chk("illegal", 32'(illegal_o), 32'(e.ill));
            chk("latency_cycle", 32'(cyc), 32'(e.cyc));
          end
          held_res = result_o;
          held_rd  = rd_addr_o;
        end else begin
          chk("held_result", result_o, held_res);
          chk("held_rd", 32'(rd_addr_o), 32'(held_rd));
        end
      end
      prev_valid = out_valid_o;
      prev_stall = stall_i;
    end
  end

  task automatic drive(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd;
  endtask

  task automatic push_exp(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat);
    exp_t e;
    logic [31:0] r;
    logic ill;
    ref_model(op, a, b, r, ill, lat);
    e.res = r; e.rd = rd; e.ill = ill; e.cyc = cyc + lat;
    expq.push_back(e);
    nissued++;
  endtask

  // Issue one op at the current cycle; optionally throw ignored ops at it while busy.
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int lat;
    push_exp(op, a, b, rd, lat);
    drive(op, a, b, rd);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy_o), 32'(k <= lat - 2));
      @(posedge clk); #1;
      if (k + 1 <= lat - 1 && $urandom_range(0, 3) == 0)
        drive(md_op_t'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
      else
        valid_i = 1'b0;
    end
  endtask

  // stall_i high in the completion cycle and the two following cycles.
  task automatic stall_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int lat;
    push_exp(op, a, b, rd, lat);
    drive(op, a, b, rd);
    stall_i = (lat - 1 == 0);
    for (int k = 0; k <= lat + 3; k++) begin
      @(negedge clk);
      if (k == lat - 1) chk("busy_completion", 32'(busy_o), 32'd0);
      if (k >= lat && k <= lat + 2) begin
        chk("stall_busy", 32'(busy_o), 32'd1);
        chk("stall_valid", 32'(out_valid_o), 32'd1);
      end
      if (k == lat + 3) begin
        chk("post_stall_busy", 32'(busy_o), 32'd0);
        chk("post_stall_valid", 32'(out_valid_o), 32'd0);
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      stall_i = (k + 1 >= lat - 1) && (k + 1 <= lat + 1);
    end
    stall_i = 1'b0;
  endtask

  task automatic squash_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input int sk);
    drive(op, a, b, 5'd9);
    for (int k = 0; k <= sk + 1; k++) begin
      @(negedge clk);
      if (k == sk + 1) begin
        chk("squash_busy", 32'(busy_o), 32'd0);
        chk("squash_valid", 32'(out_valid_o), 32'd0);
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      squash_i = (k + 1 == sk);
    end
    squash_i = 1'b0;
  endtask

  task automatic reset_mid(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input int rk);
    drive(op, a, b, 5'd17);
    for (int k = 0; k < rk; k++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_ni = 1'b0; squash_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0; md_en_i = 1'b0;
    md_op_i = MD_MUL; op1_i = '0; op2_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_rd", 32'(rd_addr_o), 32'd0);
    chk("reset_illegal", 32'(illegal_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1);
    run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2);
    run_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, 5'd3);
    run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4);
    run_op(MD_DIV,    32'd100,        32'd7,         5'd5);
    run_op(MD_REM,    32'd100,        32'd7,         5'd6);
    run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7);
    run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         5'd8);
    run_op(MD_DIVU,   32'd5,          32'd0,         5'd9);
    run_op(MD_REMU,   32'd5,          32'd0,         5'd10);
    run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11);
    run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12);
    run_op(MD_DIVU,   32'hFFFF_FFFF,  32'd3,         5'd13);

    // Squash mid-op, then the next op must complete normally
`ifdef MDU_DIV_EN
    squash_op(MD_DIV, 32'd100, 32'd7, 10);
`else
    squash_op(MD_MUL, 32'd100, 32'd7, 1);
`endif
    run_op(MD_DIV, 32'd100, 32'd7, 5'd14);
    run_op(MD_MUL, 32'd12345, 32'd678, 5'd15);

    // Stall at completion
    stall_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd16);
    stall_op(MD_DIV, 32'd100, 32'd7, 5'd18);

    // Asynchronous reset mid-op (result_o holds a nonzero value beforehand)
    run_op(MD_MUL, 32'd3, 32'd5, 5'd19);
`ifdef MDU_DIV_EN
    reset_mid(MD_DIV, 32'd1000, 32'd3, 5);
`else
    reset_mid(MD_MUL, 32'd1000, 32'd3, 1);
`endif
    run_op(MD_REM, 32'd1000, 32'd3, 5'd20);

    // Randomized traffic with idle gaps carrying non-MDU valid instructions
    for (int t = 0; t < 120; t++) begin
      run_op(md_op_t'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom));
      repeat ($urandom_range(0, 2)) begin
        valid_i = $urandom_range(0, 1) == 1;
        md_en_i = 1'b0;
        @(posedge clk); #1;
      end
      valid_i = 1'b0;
      md_en_i = 1'b1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(expq.size()), 32'd0);
    chk("output_count", 32'(nout), 32'(nissued));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
